spart_mem_ctrl: RTL and testbench
=================================

SPART_MEM_CTRL -- requirements
Module: spart_mem_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 1000000, giving the inter-byte timeout in clk cycles (20-bit counter).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all flops SHALL be rising-edge clk.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port rx_valid, input, 1, one-cycle strobe marking a received SPART byte.
REQ-005 The block SHALL have port rx_data, input, 8, the received byte, valid when rx_valid=1.
REQ-006 The block SHALL have port tx_valid, output, 1, a byte is offered to the SPART transmitter.
REQ-007 The block SHALL have port tx_data, output, 8, the offered byte.
REQ-008 The block SHALL have port tx_ready, input, 1, the transmitter accepts tx_data when tx_valid and tx_ready are both 1.
REQ-009 The block SHALL have port mem_req, output, 1, memory access request.
REQ-010 The block SHALL have port mem_we, output, 1, 1=write, 0=read, valid with mem_req.
REQ-011 The block SHALL have port mem_addr, output, 32, the access address.
REQ-012 The block SHALL have port mem_wdata, output, 32, the write data.
REQ-013 The block SHALL have port mem_rdata, input, 32, read data, valid in the mem_ack cycle.
REQ-014 The block SHALL have port mem_ack, input, 1, one-cycle access completion.
REQ-015 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-016 The block SHALL have port err, output, 1, sticky flag cleared only by reset.

Function
REQ-017 The FSM SHALL have states IDLE, ADDR, DATA, MEM, TX and SHALL leave IDLE only on rx_valid.
REQ-018 In IDLE, a command byte 8'h52 ('R') SHALL select read, 8'h57 ('W') write; any other byte SHALL load tx byte 8'hEE, set err and go to TX.
REQ-019 ADDR SHALL collect 4 bytes LSB first into mem_addr; after the 4th byte a read SHALL go to MEM and a write to DATA.
REQ-020 DATA SHALL collect 4 bytes LSB first into mem_wdata, then go to MEM.
REQ-021 mem_req SHALL assert in the cycle after the last rx_valid byte, SHALL hold until the cycle mem_ack=1, and SHALL be 0 the following cycle.
REQ-022 On mem_ack in a read, mem_rdata SHALL be captured; TX SHALL then send 4 bytes LSB first. In a write, TX SHALL send the single byte 8'hA5.
REQ-023 tx_valid SHALL assert the cycle after entry to TX; tx_data SHALL hold stable until accepted. The next byte SHALL be offered in the cycle after the handshake, with no bubble.
REQ-024 After the last byte is accepted, the FSM SHALL be in IDLE the next cycle.
REQ-025 rx_valid in MEM or TX SHALL be dropped and SHALL set err.
REQ-026 mem_ack outside MEM SHALL be ignored.
REQ-027 mem_addr and mem_wdata SHALL hold their last values while in IDLE.

Reset
REQ-028 Asserting rst at any time, including mid-access or mid-transmit, SHALL immediately force IDLE.
REQ-029 Reset SHALL force the following values: mem_req=0, mem_we=0, tx_valid=0, tx_data=0, mem_addr=0, mem_wdata=0, busy=0, err=0, and byte counter and timeout counter to 0.
REQ-030 A pending memory access SHALL be abandoned on reset, and no response SHALL be sent.

Configuration
REQ-031 With SPART_CTRL_TIMEOUT_EN defined, a counter SHALL reset on each rx_valid in ADDR or DATA. When it reaches TIMEOUT_CYC, the FSM SHALL return to IDLE, set err, issue no mem_req and transmit nothing.
REQ-032 Without SPART_CTRL_TIMEOUT_EN, the counter logic SHALL be absent, and ADDR and DATA SHALL wait indefinitely.

Verification
REQ-033 Read: bytes 52,10,00,00,00 with mem_rdata=32'hDEADBEEF on ack -> mem_addr=32'h00000010, mem_we=0, tx bytes EF,BE,AD,DE.
REQ-034 Write: bytes 57,04,00,00,00,78,56,34,12 -> one mem_req with mem_we=1, mem_addr=4, mem_wdata=32'h12345678; then tx byte A5.
REQ-035 Bad command: byte 8'h55 -> tx byte EE, err=1, no mem_req.
REQ-036 Backpressure: tx_ready held 0 for 50 cycles during a read -> tx_data stable with no byte lost; rx_valid during TX sets err.
REQ-037 Timeout (macro on, TIMEOUT_CYC=100): bytes 52,10 then idle for 100 cycles -> IDLE, err=1, no mem_req.
REQ-038 Reset: rst low while mem_req=1 -> all outputs are at reset values in the same cycle, and the next 'R' command completes normally.

Source files
------------

// File: rtl/spart_mem_ctrl.sv
// SPART command front-end: 'R'/'W' byte commands become 32-bit memory accesses; replies go back as bytes.
// Optional inter-byte timeout in ADDR/DATA is built only when SPART_CTRL_TIMEOUT_EN is defined.
module spart_mem_ctrl #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    MEM,
    TX
  } state_t;

  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] RSP_BAD   = 8'hEE;
  localparam logic [7:0] RSP_WACK  = 8'hA5;

  state_t      r_state;
  logic [1:0]  r_byte_cnt;
  logic [1:0]  r_tx_last;
  logic [31:0] r_tx_buf;
  logic        w_collecting;

  assign w_collecting = (r_state == ADDR) || (r_state == DATA);

`ifdef SPART_CTRL_TIMEOUT_EN
  localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYC - 1);

  logic [19:0] r_timeout;
  logic        w_timeout_hit;

  assign w_timeout_hit = w_collecting && !rx_valid && (r_timeout == TIMEOUT_LAST);

  // Counts idle cycles between command bytes; any received byte restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timeout <= '0;
    end else if (w_collecting && !rx_valid) begin
      r_timeout <= r_timeout + 20'd1;
    end else begin
      r_timeout <= '0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_byte_cnt <= '0;
      r_tx_last  <= '0;
      r_tx_buf   <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (rx_valid) begin
            r_byte_cnt <= '0;
            busy       <= 1'b1;
            if (rx_data == CMD_READ) begin
              mem_we  <= 1'b0;
              r_state <= ADDR;
            end else if (rx_data == CMD_WRITE) begin
              mem_we  <= 1'b1;
              r_state <= ADDR;
            end else begin
              tx_data   <= RSP_BAD;
              tx_valid  <= 1'b1;
              r_tx_last <= 2'd0;
              err       <= 1'b1;
              r_state   <= TX;
            end
          end
        end

        ADDR: begin
`ifdef SPART_CTRL_TIMEOUT_EN
          if (w_timeout_hit) begin
            err     <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end else
`endif
          if (rx_valid) begin
            // Shifting in from the top leaves the first (LSB) byte at [7:0] after four bytes.
            mem_addr   <= {rx_data, mem_addr[31:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              if (mem_we) begin
                r_state <= DATA;
              end else begin
                mem_req <= 1'b1;
                r_state <= MEM;
              end
            end
          end
        end

        DATA: begin
`ifdef SPART_CTRL_TIMEOUT_EN
          if (w_timeout_hit) begin
            err     <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end else
`endif
          if (rx_valid) begin
            mem_wdata  <= {rx_data, mem_wdata[31:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              mem_req <= 1'b1;
              r_state <= MEM;
            end
          end
        end

        MEM: begin
          if (rx_valid) begin
            err <= 1'b1;
          end
          if (mem_ack) begin
            mem_req    <= 1'b0;
            tx_valid   <= 1'b1;
            r_byte_cnt <= '0;
            r_state    <= TX;
            if (mem_we) begin
              tx_data   <= RSP_WACK;
              r_tx_last <= 2'd0;
            end else begin
              tx_data   <= mem_rdata[7:0];
              r_tx_buf  <= mem_rdata;
              r_tx_last <= 2'd3;
            end
          end
        end

        TX: begin
          if (rx_valid) begin
            err <= 1'b1;
          end
          // Next byte is loaded on the accepting edge so the transmitter sees no gap.
          if (tx_valid && tx_ready) begin
            if (r_byte_cnt == r_tx_last) begin
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              r_state  <= IDLE;
            end else begin
              r_byte_cnt <= r_byte_cnt + 2'd1;
              tx_data    <= r_tx_buf[15:8];
              r_tx_buf   <= {8'h00, r_tx_buf[31:8]};
            end
          end
        end

        default: begin
          tx_valid <= 1'b0;
          mem_req  <= 1'b0;
          busy     <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spart_mem_ctrl.sv
// Directed bench for spart_mem_ctrl: table of complete command transactions plus hand-written
// sequences for reset values, tx backpressure, reset mid-access and the inter-byte timeout.
module tb_spart_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic        busy;
  logic        err;

  int checkCount = 0;
  int passCount  = 0;
  int reqStarts  = 0;
  logic reqPrev  = 1'b0;

  typedef struct packed {
    logic [71:0] rx;
    int          nrx;
    logic [31:0] rdata;
    logic        expReq;
    logic        expWe;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
    logic [31:0] expTx;
    int          expNtx;
    logic        expErr;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  spart_mem_ctrl #(.TIMEOUT_CYC(100)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .err       (err)
  );

  // Counts distinct memory requests so tests can assert "exactly one" or "none".
  always @(posedge clk) begin
    reqPrev <= mem_req;
    if (mem_req && !reqPrev) reqStarts <= reqStarts + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
  endtask

  task automatic doReset();
    rx_valid = 1'b0;
    mem_ack  = 1'b0;
    tx_ready = 1'b0;
    rst      = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic sendByte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic collectTx(input int n, output int got, output int cyc, output logic [31:0] bytes);
    got   = 0;
    cyc   = 0;
    bytes = '0;
    tx_ready = 1'b1;
    while (got < n && cyc < 40) begin
      if (tx_valid) begin
        bytes[8*got +: 8] = tx_data;
        got++;
      end
      tick();
      cyc++;
    end
    tx_ready = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int reqBase;
    int got;
    int cyc;
    logic [31:0] bytes;
    reqBase = reqStarts;
    for (int i = 0; i < v.nrx; i++) sendByte(v.rx[8*i +: 8]);
    if (v.expReq) begin
      checkOutput($sformatf("v%0d.memReqRise", idx), {31'b0, mem_req}, 32'd1);
      checkOutput($sformatf("v%0d.memAddr", idx), mem_addr, v.expAddr);
      checkOutput($sformatf("v%0d.memWe", idx), {31'b0, mem_we}, {31'b0, v.expWe});
      checkOutput($sformatf("v%0d.memWdata", idx), mem_wdata, v.expWdata);
      tick();
      tick();
      checkOutput($sformatf("v%0d.memReqHold", idx), {31'b0, mem_req}, 32'd1);
      mem_rdata = v.rdata;
      mem_ack   = 1'b1;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = 32'h0BAD0BAD;
      checkOutput($sformatf("v%0d.memReqDrop", idx), {31'b0, mem_req}, 32'd0);
    end
    checkOutput($sformatf("v%0d.txValidStart", idx), {31'b0, tx_valid}, 32'd1);
    collectTx(v.expNtx, got, cyc, bytes);
    checkOutput($sformatf("v%0d.txCount", idx), got, v.expNtx);
    checkOutput($sformatf("v%0d.txNoBubble", idx), cyc, v.expNtx);
    checkOutput($sformatf("v%0d.txBytes", idx), bytes, v.expTx);
    checkOutput($sformatf("v%0d.idleBusy", idx), {31'b0, busy}, 32'd0);
    checkOutput($sformatf("v%0d.txValidEnd", idx), {31'b0, tx_valid}, 32'd0);
    checkOutput($sformatf("v%0d.err", idx), {31'b0, err}, {31'b0, v.expErr});
    checkOutput($sformatf("v%0d.reqCount", idx), reqStarts - reqBase, v.expReq ? 32'd1 : 32'd0);
  endtask

  initial begin
    int got;
    int cyc;
    int base;
    logic [31:0] bytes;
    logic stable;

    vecs[0] = '{rx: {32'h0, 32'h00000010, 8'h52}, nrx: 5, rdata: 32'hDEADBEEF, expReq: 1'b1,
                expWe: 1'b0, expAddr: 32'h00000010, expWdata: 32'h0, expTx: 32'hDEADBEEF,
                expNtx: 4, expErr: 1'b0};
    vecs[1] = '{rx: {32'h12345678, 32'h00000004, 8'h57}, nrx: 9, rdata: 32'h0, expReq: 1'b1,
                expWe: 1'b1, expAddr: 32'h00000004, expWdata: 32'h12345678, expTx: 32'h000000A5,
                expNtx: 1, expErr: 1'b0};
    vecs[2] = '{rx: {64'h0, 8'h55}, nrx: 1, rdata: 32'h0, expReq: 1'b0,
                expWe: 1'b0, expAddr: 32'h0, expWdata: 32'h0, expTx: 32'h000000EE,
                expNtx: 1, expErr: 1'b1};
    vecs[3] = '{rx: {32'h0, 32'h89ABCDEF, 8'h52}, nrx: 5, rdata: 32'h01020304, expReq: 1'b1,
                expWe: 1'b0, expAddr: 32'h89ABCDEF, expWdata: 32'h0, expTx: 32'h01020304,
                expNtx: 4, expErr: 1'b0};
    vecs[4] = '{rx: {32'h00000000, 32'hFFFFFFFC, 8'h57}, nrx: 9, rdata: 32'hFFFFFFFF, expReq: 1'b1,
                expWe: 1'b1, expAddr: 32'hFFFFFFFC, expWdata: 32'h00000000, expTx: 32'h000000A5,
                expNtx: 1, expErr: 1'b0};

    doReset();
    checkOutput("rst.txValid", {31'b0, tx_valid}, 32'd0);
    checkOutput("rst.txData", {24'b0, tx_data}, 32'd0);
    checkOutput("rst.memReq", {31'b0, mem_req}, 32'd0);
    checkOutput("rst.memWe", {31'b0, mem_we}, 32'd0);
    checkOutput("rst.memAddr", mem_addr, 32'd0);
    checkOutput("rst.memWdata", mem_wdata, 32'd0);
    checkOutput("rst.busy", {31'b0, busy}, 32'd0);
    checkOutput("rst.err", {31'b0, err}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      doReset();
      applyStimulus(vecs[i], i);
    end

    // Stray ack in IDLE, then a read held off by 50 cycles of backpressure with a stray rx byte.
    doReset();
    base = reqStarts;
    mem_rdata = 32'h11111111;
    mem_ack   = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    checkOutput("ackIgnored.busy", {31'b0, busy}, 32'd0);
    checkOutput("ackIgnored.txValid", {31'b0, tx_valid}, 32'd0);
    sendByte(8'h52);
    sendByte(8'h20);
    sendByte(8'h00);
    sendByte(8'h00);
    sendByte(8'h00);
    checkOutput("bp.memAddr", mem_addr, 32'h00000020);
    mem_rdata = 32'hCAFEF00D;
    mem_ack   = 1'b1;
    tick();
    mem_ack   = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (!(tx_valid === 1'b1 && tx_data === 8'h0D)) stable = 1'b0;
      rx_valid = (i == 20);
      rx_data  = 8'h57;
      tick();
      rx_valid = 1'b0;
    end
    checkOutput("bp.stable", {31'b0, stable}, 32'd1);
    checkOutput("bp.rxInTxErr", {31'b0, err}, 32'd1);
    collectTx(4, got, cyc, bytes);
    checkOutput("bp.txCount", got, 32'd4);
    checkOutput("bp.txBytes", bytes, 32'hCAFEF00D);
    checkOutput("bp.idleBusy", {31'b0, busy}, 32'd0);
    checkOutput("bp.reqCount", reqStarts - base, 32'd1);

    // Reset asserted between edges while the access is pending.
    doReset();
    sendByte(8'h52);
    sendByte(8'h30);
    sendByte(8'h00);
    sendByte(8'h00);
    sendByte(8'h00);
    checkOutput("midRst.preReq", {31'b0, mem_req}, 32'd1);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("midRst.ctrl", {19'b0, mem_req, mem_we, tx_valid, busy, err, tx_data}, 32'd0);
    checkOutput("midRst.memAddr", mem_addr, 32'd0);
    checkOutput("midRst.memWdata", mem_wdata, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    mem_rdata = 32'h22222222;
    mem_ack   = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    tick();
    checkOutput("midRst.noResp", {30'b0, tx_valid, busy}, 32'd0);
    applyStimulus(vecs[0], 90);

`ifdef SPART_CTRL_TIMEOUT_EN
    doReset();
    base = reqStarts;
    sendByte(8'h52);
    sendByte(8'h10);
    repeat (98) tick();
    checkOutput("timeout.notEarly", {31'b0, busy}, 32'd1);
    tick();
    tick();
    checkOutput("timeout.idle", {31'b0, busy}, 32'd0);
    checkOutput("timeout.err", {31'b0, err}, 32'd1);
    checkOutput("timeout.noReq", reqStarts - base, 32'd0);
    checkOutput("timeout.noTx", {31'b0, tx_valid}, 32'd0);
`else
    doReset();
    sendByte(8'h52);
    sendByte(8'h10);
    repeat (200) tick();
    checkOutput("noTimeout.waiting", {31'b0, busy}, 32'd1);
    sendByte(8'h00);
    sendByte(8'h00);
    sendByte(8'h00);
    checkOutput("noTimeout.memReq", {31'b0, mem_req}, 32'd1);
    checkOutput("noTimeout.memAddr", mem_addr, 32'h00000010);
    mem_rdata = 32'h0;
    mem_ack   = 1'b1;
    tick();
    mem_ack = 1'b0;
    collectTx(4, got, cyc, bytes);
    checkOutput("noTimeout.txCount", got, 32'd4);
    checkOutput("noTimeout.idle", {30'b0, busy, err}, 32'd0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
